// File: rtl/wait_state_memory_controller.sv
// wait_state_memory_controller: word memory with configurable non-sequential/sequential wait states
module wait_state_memory_controller #(
  parameter int    DEPTH_WORDS = 8192,
  parameter int    N_WAIT      = 2,
  parameter int    S_WAIT      = 0,
  parameter int    PRIV_LIMIT  = 256,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        write,
  input  logic        size,
  input  logic [1:0]  prot,
  input  logic [1:0]  trans,
  output logic [31:0] rdata,
  output logic        abort,
  output logic        ready
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt, w;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] r_addr, r_wdata, c_addr, c_wdata, word;
  logic        r_write, r_size, r_priv, c_write, c_size, c_priv;
  logic        seq_ok, idle, accept, done, bad;
  logic [29:0] idx;
  logic [7:0]  byte_rd;
  logic        unused_prot;
  assign unused_prot = prot[0];
  assign idle    = state == ST_IDLE;
  assign accept  = idle && trans[1];
  assign w       = (trans[0] && seq_ok) ? 4'(S_WAIT) : 4'(N_WAIT);
  assign c_addr  = idle ? addr : r_addr;
  assign c_wdata = idle ? wdata : r_wdata;
  assign c_write = idle ? write : r_write;
  assign c_size  = idle ? size : r_size;
  assign c_priv  = idle ? prot[1] : r_priv;
  assign idx     = c_addr[31:2];
  assign bad     = idx >= 30'(DEPTH_WORDS) || (c_size && c_addr[1:0] != 2'b00) ||
                   (!c_priv && idx < 30'(PRIV_LIMIT));
  assign done    = idle ? accept && w == 4'd0 : cnt == 4'd1;
  assign word    = mem[idx[AW-1:0]];
  assign byte_rd = word[{c_addr[1:0], 3'b000} +: 8];
  assign ready   = idle;

  // next state and wait counter: load W on a waited acceptance, count down while waiting
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (idle) begin
      if (accept && w != 4'd0) begin
        state_nxt = ST_WAIT;
        cnt_nxt   = w;
      end
    end else begin
      cnt_nxt = cnt - 4'd1;
      if (cnt == 4'd1) state_nxt = ST_IDLE;
    end
  end

  // control state, request latch, read data, abort pulse and burst tracking
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      rdata  <= 32'd0;
      abort  <= 1'b0;
      seq_ok <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      abort <= done && bad;
      if (done && !bad && !c_write) rdata <= c_size ? word : {24'd0, byte_rd};
      if (done && bad) seq_ok <= 1'b0;
      else if (accept) seq_ok <= 1'b1;
      else if (idle && trans == 2'b00) seq_ok <= 1'b0;
    end
  end

  // request capture; only consumed while waiting, so no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_write <= write;
      r_size  <= size;
      r_priv  <= prot[1];
    end
  end

  // memory write at the completing edge; reset suppresses a pending write
  always_ff @(posedge clk) begin
    if (n_reset && done && !bad && c_write) begin
      if (c_size) mem[idx[AW-1:0]] <= c_wdata;
      else mem[idx[AW-1:0]][{c_addr[1:0], 3'b000} +: 8] <= c_wdata[7:0];
    end
  end
endmodule

// File: tb/tb_wait_state_memory_controller.sv
// tb_wait_state_memory_controller: table vectors, corner sequences and randomized model checks
module tb_wait_state_memory_controller;
  localparam int N = 2;
  localparam int S = 0;
  typedef struct {
    logic [1:0]  tr;
    logic [31:0] a;
    logic [31:0] wd;
    logic        wr;
    logic        sz;
    logic [1:0]  pr;
    int          w;
    logic        ab;
    logic [31:0] rd;
  } rec_t;

  logic        clk = 0, n_reset = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic        write = 0, size = 0;
  logic [1:0]  prot = 0, trans = 0;
  logic [31:0] rdata;
  logic        abort, ready;
  int          errors = 0, checks = 0;
  logic [31:0] m_mem [int];
  logic [31:0] m_rd = 0;
  bit          m_seq = 0;
  rec_t        tbl[$];

  wait_state_memory_controller dut (
    .clk(clk), .n_reset(n_reset), .addr(addr), .wdata(wdata), .write(write),
    .size(size), .prot(prot), .trans(trans), .rdata(rdata), .abort(abort), .ready(ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input rec_t r, output int w, output logic ab, output logic [31:0] rd);
    int k;
    logic [31:0] t;
    k  = int'(r.a[31:2]);
    w  = (r.tr == 2'b11 && m_seq) ? S : N;
    ab = (k >= 8192) || (r.sz && r.a[1:0] != 2'b00) || (!r.pr[1] && k < 256);
    rd = m_rd;
    if (ab) m_seq = 0;
    else begin
      m_seq = 1;
      t = m_mem.exists(k) ? m_mem[k] : 32'd0;
      if (r.wr) begin
        if (r.sz) t = r.wd;
        else t[8*r.a[1:0] +: 8] = r.wd[7:0];
        m_mem[k] = t;
      end else rd = r.sz ? t : {24'd0, t[8*r.a[1:0] +: 8]};
    end
    m_rd = rd;
  endfunction

  task automatic xfer(input rec_t r, input bit use_model, input string nm);
    int mw, n;
    logic mab;
    logic [31:0] mrd;
    model(r, mw, mab, mrd);
    if (use_model) begin
      r.w  = mw;
      r.ab = mab;
      r.rd = mrd;
    end
    trans = r.tr; addr = r.a; wdata = r.wd; write = r.wr; size = r.sz; prot = r.pr;
    @(posedge clk);
    @(negedge clk);
    trans = 2'b01; addr = $urandom; wdata = $urandom; write = 1'($urandom);
    size = 1'($urandom); prot = 2'($urandom);
    n = 0;
    while (!ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({nm, " waits"}, n, r.w);
    chk({nm, " abort"}, {31'd0, abort}, {31'd0, r.ab});
    chk({nm, " rdata"}, rdata, r.rd);
  endtask

  task automatic gap(input int n, input logic [1:0] tr);
    repeat (n) begin
      trans = tr;
      addr  = $urandom;
      @(posedge clk);
      @(negedge clk);
      if (tr == 2'b00) m_seq = 0;
      chk("gap abort", {31'd0, abort}, 32'd0);
      chk("gap ready", {31'd0, ready}, 32'd1);
      chk("gap rdata", rdata, m_rd);
    end
  endtask

  function automatic rec_t mk(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] wd,
                              input logic wr, input logic sz, input logic [1:0] pr,
                              input int w, input logic ab, input logic [31:0] rd);
    rec_t r;
    r.tr = tr; r.a = a; r.wd = wd; r.wr = wr; r.sz = sz; r.pr = pr; r.w = w; r.ab = ab; r.rd = rd;
    return r;
  endfunction

  initial begin
    rec_t r;
    tbl.push_back(mk(2'b10, 32'h400,  32'hDEADBEEF, 1, 1, 2'b11, 2, 0, 32'h0));
    tbl.push_back(mk(2'b11, 32'h404,  32'h01020304, 1, 1, 2'b11, 0, 0, 32'h0));
    tbl.push_back(mk(2'b11, 32'h408,  32'hA5A5A5A5, 1, 1, 2'b11, 0, 0, 32'h0));
    tbl.push_back(mk(2'b10, 32'h400,  32'h0,        0, 1, 2'b11, 2, 0, 32'hDEADBEEF));
    tbl.push_back(mk(2'b11, 32'h404,  32'h0,        0, 1, 2'b11, 0, 0, 32'h01020304));
    tbl.push_back(mk(2'b11, 32'h408,  32'h0,        0, 1, 2'b11, 0, 0, 32'hA5A5A5A5));
    tbl.push_back(mk(2'b10, 32'h400,  32'h11223344, 1, 1, 2'b11, 2, 0, 32'hA5A5A5A5));
    tbl.push_back(mk(2'b11, 32'h402,  32'hFFFFFFAA, 1, 0, 2'b11, 0, 0, 32'hA5A5A5A5));
    tbl.push_back(mk(2'b11, 32'h400,  32'h0,        0, 1, 2'b11, 0, 0, 32'h11AA3344));
    tbl.push_back(mk(2'b11, 32'h403,  32'h0,        0, 0, 2'b11, 0, 0, 32'h00000011));
    tbl.push_back(mk(2'b11, 32'h401,  32'h0,        0, 1, 2'b11, 0, 1, 32'h00000011));
    tbl.push_back(mk(2'b11, 32'h404,  32'h0,        0, 1, 2'b11, 2, 0, 32'h01020304));
    tbl.push_back(mk(2'b11, 32'h8000, 32'hDEADDEAD, 1, 1, 2'b11, 0, 1, 32'h01020304));
    tbl.push_back(mk(2'b10, 32'h10,   32'h0,        0, 1, 2'b00, 2, 1, 32'h01020304));
    tbl.push_back(mk(2'b10, 32'h400,  32'h0,        0, 1, 2'b01, 2, 0, 32'h11AA3344));
    tbl.push_back(mk(2'b11, 32'h3FC,  32'h0,        0, 1, 2'b01, 0, 1, 32'h11AA3344));
    tbl.push_back(mk(2'b10, 32'h7FFC, 32'hCAFEF00D, 1, 1, 2'b11, 2, 0, 32'h11AA3344));
    tbl.push_back(mk(2'b11, 32'h7FFC, 32'h0,        0, 1, 2'b11, 0, 0, 32'hCAFEF00D));
    tbl.push_back(mk(2'b10, 32'h10,   32'h12345678, 1, 1, 2'b10, 2, 0, 32'hCAFEF00D));
    tbl.push_back(mk(2'b11, 32'h10,   32'h99999999, 1, 1, 2'b00, 0, 1, 32'hCAFEF00D));
    tbl.push_back(mk(2'b11, 32'h10,   32'h0,        0, 1, 2'b10, 2, 0, 32'h12345678));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", {31'd0, ready}, 32'd1);
    chk("reset abort", {31'd0, abort}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    n_reset = 1;

    for (int i = 0; i < tbl.size(); i++) xfer(tbl[i], 0, $sformatf("vec%0d", i));

    gap(1, 2'b01);
    xfer(mk(2'b11, 32'h400, 32'h0, 0, 1, 2'b11, 0, 0, 32'h11AA3344), 0, "busy keeps seq");
    gap(1, 2'b00);
    xfer(mk(2'b11, 32'h404, 32'h0, 0, 1, 2'b11, 2, 0, 32'h01020304), 0, "idle breaks seq");

    trans = 2'b10; addr = 32'h400; wdata = 32'h55555555; write = 1; size = 1; prot = 2'b11;
    @(posedge clk);
    @(negedge clk);
    trans = 2'b00;
    n_reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midwait reset ready", {31'd0, ready}, 32'd1);
    chk("midwait reset abort", {31'd0, abort}, 32'd0);
    chk("midwait reset rdata", rdata, 32'd0);
    n_reset = 1;
    m_rd = 0;
    m_seq = 0;
    xfer(mk(2'b10, 32'h400, 32'h0, 0, 1, 2'b11, 2, 0, 32'h11AA3344), 0, "reset drops write");

    for (int i = 0; i < 32; i++)
      xfer(mk(2'($urandom_range(2, 3)), 32'h400 + 4 * i, $urandom, 1, 1, 2'b11, 0, 0, 0), 1, "prefill");

    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 99);
      r = mk(2'($urandom_range(2, 3)), 32'h400 + 4 * $urandom_range(0, 31), $urandom,
             1'($urandom), 1'($urandom), 2'($urandom), 0, 0, 0);
      if (!r.sz) r.a[1:0] = 2'($urandom);
      if (k < 8) r.a = 32'h8000 + 4 * $urandom_range(0, 4095);
      else if (k < 16) r.a = r.a | 32'($urandom_range(1, 3));
      else if (k < 22) begin
        r.a = 32'($urandom_range(0, 255)) << 2;
        r.pr[1] = 0;
      end
      xfer(r, 1, "random");
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2), 2'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
